out_display_driver: RTL



---
 rtl/my8_disp_pkg.sv | 25 ++
 rtl/out_display_driver_seg7_decoder.sv | 12 +
 rtl/out_display_driver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/my8_disp_pkg.sv
// Shared types and constants for the OUT-register display driver:
// FSM encoding, active-low segment patterns, digit enables and BCD length.
package my8_disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } disp_state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Index 0 is the rightmost element: SEG_PATTERN[4'hX] is the glyph for X.
   localparam logic [15:0][7:0] SEG_PATTERN = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   localparam logic [2:0] DIGIT_ONES     = 3'b110;
   localparam logic [2:0] DIGIT_TENS     = 3'b101;
   localparam logic [2:0] DIGIT_HUNDREDS = 3'b011;

   localparam int BCD_ITERS = 8;

endpackage

// File: rtl/out_display_driver_seg7_decoder.sv
// Combinational nibble-to-segment decoder (active-low, dp off) with blank override.
module seg7_decoder
   import my8_disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [7:0] seg
);

   assign seg = blank ? SEG_BLANK : SEG_PATTERN[value];

endmodule

// File: rtl/out_display_driver.sv
// Shows the CPU OUT byte on a 3-digit multiplexed common-anode display.
// OUT_DISPLAY_BCD_EN selects decimal (double-dabble) instead of hex.
module out_display_driver
   import my8_disp_pkg::*;
#(
   parameter int SCAN_DIV = 4
) (
   input  logic       clock,
   input  logic       nReset,
   input  logic [7:0] IN,
   output logic [7:0] SEG,
   output logic [2:0] DIGIT
);

   localparam int              PS_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

   disp_state_t     state_reg;
   logic [7:0]      last_val_reg;
   logic [7:0]      shadow_reg;
   logic [3:0]      d0_reg, d1_reg, d2_reg;
   logic [PS_W-1:0] prescale_reg;
   logic [1:0]      scan_idx_reg, scan_idx_next;
   logic            scan_wrap;
   logic [7:0]      seg_reg, seg_next;
   logic [2:0]      digit_reg, digit_next;

   logic [3:0]      digit_val   [3];
   logic            digit_blank [3];
   logic [7:0]      digit_seg   [3];

   genvar gi;

`ifdef OUT_DISPLAY_BCD_EN
   logic [11:0] bcd_reg;
   logic [11:0] bcd_adj;
   logic [2:0]  iter_reg;

   for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
   end
`endif

   // Capture / convert / load. Display regs change only in LOAD, so the
   // scanner never sees a half-converted value.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_reg    <= IDLE;
         last_val_reg <= '0;
         shadow_reg   <= '0;
         d0_reg       <= '0;
         d1_reg       <= '0;
         d2_reg       <= '0;
`ifdef OUT_DISPLAY_BCD_EN
         bcd_reg      <= '0;
         iter_reg     <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (IN != last_val_reg) begin
                  last_val_reg <= IN;
                  shadow_reg   <= IN;
`ifdef OUT_DISPLAY_BCD_EN
                  bcd_reg      <= '0;
                  iter_reg     <= '0;
                  state_reg    <= CONV;
`else
                  state_reg    <= LOAD;
`endif
               end
            end
`ifdef OUT_DISPLAY_BCD_EN
            CONV: begin
               {bcd_reg, shadow_reg} <= {bcd_adj, shadow_reg} << 1;
               iter_reg              <= iter_reg + 3'd1;
               if (iter_reg == 3'(BCD_ITERS - 1))
                  state_reg <= LOAD;
            end
`endif
            LOAD: begin
`ifdef OUT_DISPLAY_BCD_EN
               d2_reg <= bcd_reg[11:8];
               d1_reg <= bcd_reg[7:4];
               d0_reg <= bcd_reg[3:0];
`else
               d1_reg <= shadow_reg[7:4];
               d0_reg <= shadow_reg[3:0];
`endif
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign digit_val[0]   = d0_reg;
   assign digit_val[1]   = d1_reg;
   assign digit_val[2]   = d2_reg;
   assign digit_blank[0] = 1'b0;
`ifdef OUT_DISPLAY_BCD_EN
   assign digit_blank[1] = (d2_reg == 4'd0) && (d1_reg == 4'd0);
   assign digit_blank[2] = (d2_reg == 4'd0);
`else
   assign digit_blank[1] = 1'b0;
   assign digit_blank[2] = 1'b1;
`endif

   for (gi = 0; gi < 3; gi++) begin : g_dec
      seg7_decoder u_dec (
         .value (digit_val[gi]),
         .blank (digit_blank[gi]),
         .seg   (digit_seg[gi])
      );
   end

   always_comb begin
      scan_wrap     = (prescale_reg == PS_LAST);
      scan_idx_next = scan_idx_reg;
      if (scan_wrap)
         scan_idx_next = (scan_idx_reg == 2'd2) ? 2'd0 : scan_idx_reg + 2'd1;
      case (scan_idx_next)
         2'd1: begin
            seg_next   = digit_seg[1];
            digit_next = DIGIT_TENS;
         end
         2'd2: begin
            seg_next   = digit_seg[2];
            digit_next = DIGIT_HUNDREDS;
         end
         default: begin
            seg_next   = digit_seg[0];
            digit_next = DIGIT_ONES;
         end
      endcase
   end

   // SEG and DIGIT share one register stage so they always switch together.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         prescale_reg <= '0;
         scan_idx_reg <= '0;
         seg_reg      <= SEG_PATTERN[0];
         digit_reg    <= DIGIT_ONES;
      end else begin
         prescale_reg <= scan_wrap ? '0 : prescale_reg + PS_W'(1);
         scan_idx_reg <= scan_idx_next;
         seg_reg      <= seg_next;
         digit_reg    <= digit_next;
      end
   end

   assign SEG   = seg_reg;
   assign DIGIT = digit_reg;

endmodule
